// File: rtl/ftoi_pipe_if.sv
// Handshake and data bundle for the binary32 -> int32 converter.
// master drives operands and out_ready; slave is the converter.
interface ftoi_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        nv;
  logic        nx;

  modport master (
    output in_valid, x, rm, out_ready,
    input  in_ready, out_valid, y, nv, nx
  );

  modport slave (
    input  in_valid, x, rm, out_ready,
    output in_ready, out_valid, y, nv, nx
  );
endinterface

// File: rtl/ftoi_pipe.sv
// Pipelined IEEE-754 binary32 to signed int32 converter, NSTAGE (1..3) stages.
// Define FTOI_SAT_EN to saturate invalid results by sign instead of returning 0x80000000.
module ftoi_pipe #(
  parameter int NSTAGE = 2
) (
  input logic       clk,
  input logic       rstn,
  ftoi_pipe_if.slave bus
);

  typedef struct packed {
    logic        s;
`ifdef FTOI_SAT_EN
    logic        nan;
`endif
    logic        naninf;
    logic        huge;
    logic [32:0] mag;
    logic        g;
    logic        t;
    logic [1:0]  rm;
  } dec_t;

  typedef struct packed {
    logic [31:0] y;
    logic        nv;
    logic        nx;
  } res_t;

  // Truncated magnitude plus guard/sticky; huge marks shifts that cannot fit 33 bits.
  function automatic dec_t decode(input logic [31:0] f, input logic [1:0] rmode);
    dec_t        d;
    logic [7:0]  e;
    logic [23:0] sig;
    logic [49:0] ext;
    logic [7:0]  sh;
    d      = '0;
    e      = f[30:23];
    sig    = {|e, f[22:0]};
    d.s    = f[31];
    d.rm   = rmode;
    d.naninf = (e == 8'hFF);
`ifdef FTOI_SAT_EN
    d.nan  = (e == 8'hFF) && (f[22:0] != 23'd0);
`endif
    if (e >= 8'd150) begin
      sh = e - 8'd150;
      if (sh >= 8'd9)
        d.huge = 1'b1;
      else
        d.mag = {9'd0, sig} << sh;
    end else begin
      sh = 8'd150 - e;
      if (sh > 8'd26)
        sh = 8'd26;
      ext   = {sig, 26'd0} >> sh;
      d.mag = {9'd0, ext[49:26]};
      d.g   = ext[25];
      d.t   = |ext[24:0];
    end
    return d;
  endfunction

  function automatic res_t round_res(input dec_t d);
    res_t        r;
    logic        inc;
    logic [32:0] rmag;
    logic        inv;
    case (d.rm)
      2'b00:   inc = d.g & (d.t | d.mag[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = d.s & (d.g | d.t);
      default: inc = ~d.s & (d.g | d.t);
    endcase
    rmag = d.mag + {32'd0, inc};
    inv  = d.naninf | d.huge |
           (d.s ? (rmag > 33'h0_8000_0000) : (rmag > 33'h0_7FFF_FFFF));
    r.nv = inv;
    r.nx = ~inv & (d.g | d.t);
    if (!inv)
      r.y = d.s ? (32'd0 - rmag[31:0]) : rmag[31:0];
    else begin
`ifdef FTOI_SAT_EN
      r.y = (d.nan || !d.s) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
      r.y = 32'h8000_0000;
`endif
    end
    return r;
  endfunction

  logic w_en;
  dec_t w_dec;
  dec_t w_dec_q;
  logic w_v_q;
  res_t w_res;

  // One global enable: the whole pipe freezes while the output is stalled.
  assign w_en         = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = w_en;
  assign w_dec        = decode(bus.x, bus.rm);

  generate
    if (NSTAGE >= 2) begin : g_s1
      dec_t r_dec;
      logic r_v1;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_dec <= '0;
          r_v1  <= 1'b0;
        end else if (w_en) begin
          r_v1 <= bus.in_valid;
          if (bus.in_valid)
            r_dec <= w_dec;
        end
      end
      assign w_dec_q = r_dec;
      assign w_v_q   = r_v1;
    end else begin : g_s1_bypass
      assign w_dec_q = w_dec;
      assign w_v_q   = bus.in_valid;
    end
  endgenerate

  assign w_res = round_res(w_dec_q);

  res_t r_res;
  logic r_v2;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res <= '0;
      r_v2  <= 1'b0;
    end else if (w_en) begin
      r_v2 <= w_v_q;
      if (w_v_q)
        r_res <= w_res;
    end
  end

  generate
    if (NSTAGE >= 3) begin : g_s3
      res_t r_out;
      logic r_v3;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_out <= '0;
          r_v3  <= 1'b0;
        end else if (w_en) begin
          r_v3 <= r_v2;
          if (r_v2)
            r_out <= r_res;
        end
      end
      assign bus.out_valid = r_v3;
      assign bus.y         = r_out.y;
      assign bus.nv        = r_out.nv;
      assign bus.nx        = r_out.nx;
    end else begin : g_s3_bypass
      assign bus.out_valid = r_v2;
      assign bus.y         = r_res.y;
      assign bus.nv        = r_res.nv;
      assign bus.nx        = r_res.nx;
    end
  endgenerate

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: directed vectors, random stream, stall and reset.
// Expected results come from a hand table and an independent real-arithmetic model.
module tb_ftoi_pipe;
  localparam int NSTAGE = 2;

`ifdef FTOI_SAT_EN
  localparam logic [31:0] INVP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] INVP = 32'h8000_0000;
`endif

  typedef struct packed {
    logic [31:0] y;
    logic        nv;
    logic        nx;
  } exp_t;

  // {x, rm, y, nv, nx}
  localparam int ND = 28;
  localparam logic [67:0] DV [ND] = '{
    {32'h40200000, 2'd0, 32'h00000002, 1'b0, 1'b1},
    {32'h40200000, 2'd1, 32'h00000002, 1'b0, 1'b1},
    {32'h40200000, 2'd2, 32'h00000002, 1'b0, 1'b1},
    {32'h40200000, 2'd3, 32'h00000003, 1'b0, 1'b1},
    {32'hC0200000, 2'd0, 32'hFFFFFFFE, 1'b0, 1'b1},
    {32'hC0200000, 2'd1, 32'hFFFFFFFE, 1'b0, 1'b1},
    {32'hC0200000, 2'd2, 32'hFFFFFFFD, 1'b0, 1'b1},
    {32'hC0200000, 2'd3, 32'hFFFFFFFE, 1'b0, 1'b1},
    {32'h4F000000, 2'd0, INVP,         1'b1, 1'b0},
    {32'hCF000000, 2'd0, 32'h80000000, 1'b0, 1'b0},
    {32'h7FC00000, 2'd0, INVP,         1'b1, 1'b0},
    {32'h00000001, 2'd3, 32'h00000001, 1'b0, 1'b1},
    {32'h80000000, 2'd0, 32'h00000000, 1'b0, 1'b0},
    {32'h80000001, 2'd2, 32'hFFFFFFFF, 1'b0, 1'b1},
    {32'hFF800000, 2'd0, 32'h80000000, 1'b1, 1'b0},
    {32'h7F800000, 2'd1, INVP,         1'b1, 1'b0},
    {32'h4EFFFFFF, 2'd0, 32'h7FFFFF80, 1'b0, 1'b0},
    {32'h3F000000, 2'd0, 32'h00000000, 1'b0, 1'b1},
    {32'h3F000000, 2'd3, 32'h00000001, 1'b0, 1'b1},
    {32'hBF000000, 2'd0, 32'h00000000, 1'b0, 1'b1},
    {32'h40600000, 2'd0, 32'h00000004, 1'b0, 1'b1},
    {32'h3FC00000, 2'd0, 32'h00000002, 1'b0, 1'b1},
    {32'hCF000001, 2'd1, 32'h80000000, 1'b1, 1'b0},
    {32'h3F800000, 2'd2, 32'h00000001, 1'b0, 1'b0},
    {32'h4F000000, 2'd1, INVP,         1'b1, 1'b0},
    {32'hCEFFFFFF, 2'd2, 32'h80000080, 1'b0, 1'b0},
    {32'hBF000000, 2'd2, 32'hFFFFFFFF, 1'b0, 1'b1},
    {32'h3F7FFFFF, 2'd0, 32'h00000001, 1'b0, 1'b1}
  };

  logic clk = 1'b0;
  logic rstn;
  ftoi_pipe_if bus();

  ftoi_pipe #(.NSTAGE(NSTAGE)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_xfer_cyc = 0;
  int   first_ov_cyc  = -1;
  logic armed = 1'b0;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Independent reference: exact value in double precision, then real rounding.
  function automatic exp_t model(input logic [31:0] f, input logic [1:0] rmv);
    exp_t   e;
    real    v, fl, ce, r;
    int     ex, ex2;
    longint li;
    e  = '0;
    ex = int'(f[30:23]);
    if (ex == 255) begin
      e.nv = 1'b1;
`ifdef FTOI_SAT_EN
      e.y = ((f[22:0] != 23'd0) || !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
      e.y = 32'h8000_0000;
`endif
      return e;
    end
    v   = real'(int'({(ex != 0), f[22:0]}));
    ex2 = (ex == 0) ? -149 : ex - 150;
    if (ex2 > 0) repeat (ex2) v = v * 2.0;
    else         repeat (-ex2) v = v / 2.0;
    if (f[31]) v = -v;
    fl = $floor(v);
    ce = $ceil(v);
    case (rmv)
      2'd0: begin
        if (v - fl < 0.5)      r = fl;
        else if (v - fl > 0.5) r = ce;
        else                   r = ($floor(fl / 2.0) * 2.0 == fl) ? fl : ce;
      end
      2'd1:    r = (v < 0.0) ? ce : fl;
      2'd2:    r = fl;
      default: r = ce;
    endcase
    if (r < -2147483648.0 || r > 2147483647.0) begin
      e.nv = 1'b1;
`ifdef FTOI_SAT_EN
      e.y = (r > 0.0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
      e.y = 32'h8000_0000;
`endif
    end else begin
      li   = longint'(r);
      e.y  = li[31:0];
      e.nx = (r != v);
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] xv, input logic [1:0] rmv, input exp_t ex);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.x        = xv;
    bus.rm       = rmv;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(ex);
        last_xfer_cyc = cyc;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready within 200 cycles, required acceptance");
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int         k;
    k = int'($urandom_range(0, 15));
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'd255;
    else             e = 8'($urandom_range(118, 160));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic send_rand();
    logic [31:0] xv;
    logic [1:0]  rmv;
    xv  = rand_op();
    rmv = 2'($urandom_range(0, 3));
    send(xv, rmv, model(xv, rmv));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && armed && bus.out_valid) begin
      first_ov_cyc = cyc;
      armed        = 1'b0;
    end
    if (rstn && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got y=%h nv=%b nx=%b, required no output",
                 bus.y, bus.nv, bus.nx);
      end else begin
        exp_t ex;
        ex = sb_q.pop_front();
        chk("result", 64'({bus.y, bus.nv, bus.nx}), 64'({ex.y, ex.nv, ex.nx}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [67:0] v;
    logic [31:0] y_hold;
    int          t0;
    exp_t        ex;

    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = 32'd0;
    bus.rm        = 2'd0;
    bus.out_ready = 1'b1;
    #3;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_y", 64'(bus.y), 64'd0);
    chk("reset_flags", 64'({bus.nv, bus.nx}), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < ND; i++) begin
      v = DV[i];
      ex.y  = v[33:2];
      ex.nv = v[1];
      ex.nx = v[0];
      send(v[67:36], v[35:34], ex);
    end
    drain();

    armed = 1'b1;
    send_rand();
    t0 = last_xfer_cyc;
    for (int i = 1; i < 32; i++) send_rand();
    drain();
    chk("latency", 64'(first_ov_cyc - t0), 64'(NSTAGE));

    fork
      begin
        for (int i = 0; i < 16; i++) send_rand();
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        y_hold = bus.y;
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
          chk("stall_y", 64'(bus.y), 64'(y_hold));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    ex.y = 32'd3; ex.nv = 1'b0; ex.nx = 1'b1;
    send(32'h40200000, 2'd3, ex);
    ex.y = 32'hFFFFFFFD;
    send(32'hC0200000, 2'd2, ex);
    #2 rstn = 1'b0;
    sb_q.delete();
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_y", 64'(bus.y), 64'd0);
    chk("midreset_flags", 64'({bus.nv, bus.nx}), 64'd0);
    chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale_valid", 64'(bus.out_valid), 64'd0);

    ex.y = 32'd2; ex.nv = 1'b0; ex.nx = 1'b1;
    send(32'h40200000, 2'd1, ex);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
